// File: rtl/shift_add_mult.sv
// -----------------------------------------------------------------------------
// shift_add_mult
//
// Purpose:
//   Parametrised N x N shift-and-add multiplier. A (2N+1)-bit accumulator
//   starts as {0, multiplier}. Each RUN cycle it conditionally adds the
//   multiplicand into its upper half and shifts right by one. After N such
//   cycles the low 2N bits hold the product. A start/busy/done handshake
//   frames each operation. The product stays on the output until the next
//   accepted start.
//
// Parameters:
//   N        operand width in bits (N >= 2)
//
// Ports:
//   clk      input   1    rising-edge clock
//   rst      input   1    synchronous, active-high reset
//   start    input   1    sample operands and begin a multiply (IDLE/DONE only)
//   mcand    input   N    multiplicand, sampled on the accepting edge
//   mplier   input   N    multiplier, sampled on the accepting edge
//   sgn      input   1    (SHIFT_ADD_SIGNED_EN only) operands are two's complement
//   busy     output  1    high while iterating (RUN)
//   done     output  1    one-cycle pulse: product valid
//   product  output  2N   accumulator low 2N bits
//
// Configuration macro:
//   SHIFT_ADD_SIGNED_EN  adds the sgn port and signed (sign-magnitude) support
// -----------------------------------------------------------------------------
module shift_add_mult #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   mcand,
  input  logic [N-1:0]   mplier,
`ifdef SHIFT_ADD_SIGNED_EN
  input  logic           sgn,
`endif
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [2*N:0]    acc_q, acc_d;
  logic [N-1:0]    mcand_q, mcand_d;
  logic [CW-1:0]   count_q, count_d;

  logic            accept;
  logic            lastStep;
  logic [N:0]      upper;
  logic [2*N:0]    shifted;
  logic [N-1:0]    mcandMag;
  logic [N-1:0]    mplierMag;

`ifdef SHIFT_ADD_SIGNED_EN
  logic            neg_q, neg_d;
  logic            negNext;

  // The core only multiplies magnitudes. Negative operands are folded to
  // their magnitude at accept time. The most negative value maps onto
  // 2^(N-1), which still fits in N unsigned bits.
  always_comb begin
    mcandMag  = (sgn && mcand[N-1])  ? -mcand  : mcand;
    mplierMag = (sgn && mplier[N-1]) ? -mplier : mplier;
    negNext   = sgn && (mcand[N-1] ^ mplier[N-1]);
  end
`else
  always_comb begin
    mcandMag  = mcand;
    mplierMag = mplier;
  end
`endif

  // A new operation can be accepted from IDLE or from DONE. Accepting from
  // DONE lets a caller run back-to-back operations.
  assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
  assign lastStep = (state_q == RUN) && (count_q == CW'(N - 1));

  // One iteration: add into the upper N+1 bits, then shift the whole
  // accumulator right. The extra top bit holds the carry of the add.
  assign upper   = acc_q[2*N:N] + {1'b0, (acc_q[0] ? mcand_q : {N{1'b0}})};
  assign shifted = {upper, acc_q[N-1:0]} >> 1;

  // State register plus datapath registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      count_q <= '0;
`ifdef SHIFT_ADD_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      count_q <= count_d;
`ifdef SHIFT_ADD_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

  // Next-state logic. A start seen during RUN is deliberately ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (lastStep) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values. Outside RUN and accept, everything holds, so the
  // product stays visible through DONE and IDLE.
  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    count_d = count_q;
`ifdef SHIFT_ADD_SIGNED_EN
    neg_d   = neg_q;
`endif
    if (accept) begin
      acc_d   = {{(N+1){1'b0}}, mplierMag};
      mcand_d = mcandMag;
      count_d = '0;
`ifdef SHIFT_ADD_SIGNED_EN
      neg_d   = negNext;
`endif
    end else if (state_q == RUN) begin
      acc_d   = shifted;
      count_d = count_q + CW'(1);
`ifdef SHIFT_ADD_SIGNED_EN
      // Sign is restored on the final iteration, so latency does not change.
      if (lastStep && neg_q) begin
        acc_d = {1'b0, -shifted[2*N-1:0]};
      end
`endif
    end
  end

  // Outputs decode registered state only, so they are glitch-free.
  always_comb begin
    busy    = (state_q == RUN);
    done    = (state_q == DONE);
    product = acc_q[2*N-1:0];
  end

endmodule

// File: tb/tb_shift_add_mult.sv
// -----------------------------------------------------------------------------
// tb_shift_add_mult
//
// Self-checking bench for shift_add_mult with N=4. Expected products come from
// plain integer multiplication of the operands, and expected timing comes
// from the start-to-done relationship, not from the multiplier's internals.
// -----------------------------------------------------------------------------
module tb_shift_add_mult;

  localparam int N   = 4;
  localparam int LAT = N;

  logic           clk;
  logic           rst;
  logic           start;
  logic [N-1:0]   mcand;
  logic [N-1:0]   mplier;
`ifdef SHIFT_ADD_SIGNED_EN
  logic           sgn;
`endif
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  int nChecks = 0;
  int nErrors = 0;

  shift_add_mult #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mcand   (mcand),
    .mplier  (mplier),
`ifdef SHIFT_ADD_SIGNED_EN
    .sgn     (sgn),
`endif
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product from plain arithmetic. Signed mode reinterprets the
  // operands as two's complement integers.
  function automatic logic [2*N-1:0] refMul(input int a, input int b, input bit s);
    int av, bv, p;
    av = a;
    bv = b;
    if (s && a >= (1 << (N-1))) av = a - (1 << N);
    if (s && b >= (1 << (N-1))) bv = b - (1 << N);
    p = av * bv;
    return p[2*N-1:0];
  endfunction

  // Advance one clock and settle just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands and pulse start across exactly one edge (edge E).
  task automatic applyStimulus(input int a, input int b, input bit s);
    mcand  = a[N-1:0];
    mplier = b[N-1:0];
`ifdef SHIFT_ADD_SIGNED_EN
    sgn    = s;
`else
    if (s) $display("[TB] note: signed request ignored in unsigned build");
`endif
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Count edges after E until done rises; bounded so the bench never hangs.
  task automatic waitDone(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    tick();
    tick();
    nChecks++;
    if (busy !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    nChecks++;
    if (done !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    nChecks++;
    if (product !== '0) begin nErrors++; $display("[TB] FAIL reset_product got=%h exp=00", product); end
    rst = 1'b0;
    tick();
  endtask

  // 13 x 11: busy for N cycles, done only in the cycle after E+N.
  task automatic test_timing();
    logic [2*N-1:0] exp;
    exp = refMul(13, 11, 1'b0);
    applyStimulus(13, 11, 1'b0);
    for (int k = 0; k <= LAT + 1; k++) begin
      if (k > 0) tick();
      nChecks++;
      if (busy !== (k < LAT)) begin
        nErrors++;
        $display("[TB] FAIL timing_busy k=%0d got=%b exp=%b", k, busy, (k < LAT));
      end
      nChecks++;
      if (done !== (k == LAT)) begin
        nErrors++;
        $display("[TB] FAIL timing_done k=%0d got=%b exp=%b", k, done, (k == LAT));
      end
      if (k == LAT) begin
        nChecks++;
        if (product !== exp) begin
          nErrors++;
          $display("[TB] FAIL timing_product got=%h exp=%h", product, exp);
        end
      end
    end
  endtask

  // Corner operands, each followed by 10 idle cycles with the product held.
  task automatic test_corners();
    int ops [3][2] = '{'{0, 15}, '{15, 15}, '{1, 1}};
    int cyc;
    logic [2*N-1:0] exp;
    for (int i = 0; i < 3; i++) begin
      exp = refMul(ops[i][0], ops[i][1], 1'b0);
      applyStimulus(ops[i][0], ops[i][1], 1'b0);
      waitDone(cyc);
      nChecks++;
      if (cyc !== LAT) begin nErrors++; $display("[TB] FAIL corner_latency i=%0d got=%0d exp=%0d", i, cyc, LAT); end
      nChecks++;
      if (product !== exp) begin nErrors++; $display("[TB] FAIL corner_product i=%0d got=%h exp=%h", i, product, exp); end
      for (int j = 0; j < 10; j++) begin
        tick();
        nChecks++;
        if (product !== exp) begin
          nErrors++;
          $display("[TB] FAIL corner_hold i=%0d j=%0d got=%h exp=%h", i, j, product, exp);
        end
      end
    end
  endtask

  // Start pulses during RUN with other operands must be ignored.
  task automatic test_start_ignored();
    int pulses;
    logic [2*N-1:0] exp;
    logic [2*N-1:0] atDone;
    exp = refMul(6, 7, 1'b0);
    atDone = '0;
    pulses = 0;
    applyStimulus(6, 7, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      if (k == 1) begin mcand = 4'd15; mplier = 4'd9; start = 1'b1; end
      if (k == 3) start = 1'b0;
      tick();
      if (done === 1'b1) begin pulses++; atDone = product; end
    end
    nChecks++;
    if (pulses !== 1) begin nErrors++; $display("[TB] FAIL ignore_pulses got=%0d exp=1", pulses); end
    nChecks++;
    if (atDone !== exp) begin nErrors++; $display("[TB] FAIL ignore_product got=%h exp=%h", atDone, exp); end
  endtask

  // Reset in the second RUN cycle aborts without a done, then a fresh op works.
  task automatic test_reset_mid();
    int pulses;
    int cyc;
    logic [2*N-1:0] exp;
    applyStimulus(5, 3, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nChecks++;
    if (busy !== 1'b0) begin nErrors++; $display("[TB] FAIL abort_busy got=%b exp=0", busy); end
    nChecks++;
    if (done !== 1'b0) begin nErrors++; $display("[TB] FAIL abort_done got=%b exp=0", done); end
    nChecks++;
    if (product !== '0) begin nErrors++; $display("[TB] FAIL abort_product got=%h exp=00", product); end
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    nChecks++;
    if (pulses !== 0) begin nErrors++; $display("[TB] FAIL abort_stray_done got=%0d exp=0", pulses); end
    exp = refMul(7, 9, 1'b0);
    applyStimulus(7, 9, 1'b0);
    waitDone(cyc);
    nChecks++;
    if (cyc !== LAT) begin nErrors++; $display("[TB] FAIL after_abort_latency got=%0d exp=%0d", cyc, LAT); end
    nChecks++;
    if (product !== exp) begin nErrors++; $display("[TB] FAIL after_abort_product got=%h exp=%h", product, exp); end
    tick();
  endtask

  // start held high through DONE: second op accepted there, dones 5 apart.
  task automatic test_back_to_back();
    int d1, d2;
    logic [2*N-1:0] p1, p2, e1, e2;
    e1 = refMul(3, 5, 1'b0);
    e2 = refMul(9, 14, 1'b0);
    d1 = -1; d2 = -1; p1 = '0; p2 = '0;
    mcand = 4'd3; mplier = 4'd5;
`ifdef SHIFT_ADD_SIGNED_EN
    sgn = 1'b0;
`endif
    start = 1'b1;
    tick();
    mcand = 4'd9; mplier = 4'd14;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == LAT + 1) start = 1'b0;
      if (done === 1'b1) begin
        if (d1 < 0) begin d1 = k; p1 = product; end
        else if (d2 < 0) begin d2 = k; p2 = product; end
      end
    end
    start = 1'b0;
    nChecks++;
    if (d2 - d1 !== LAT + 1 || d1 < 0 || d2 < 0) begin
      nErrors++;
      $display("[TB] FAIL b2b_spacing got d1=%0d d2=%0d exp spacing=%0d", d1, d2, LAT + 1);
    end
    nChecks++;
    if (p1 !== e1) begin nErrors++; $display("[TB] FAIL b2b_first got=%h exp=%h", p1, e1); end
    nChecks++;
    if (p2 !== e2) begin nErrors++; $display("[TB] FAIL b2b_second got=%h exp=%h", p2, e2); end
  endtask

  // Random operands with random idle gaps.
  task automatic test_random();
    int a, b, cyc, gap;
    bit s;
    logic [2*N-1:0] exp;
    for (int i = 0; i < 30; i++) begin
      a = $urandom_range(0, (1 << N) - 1);
      b = $urandom_range(0, (1 << N) - 1);
`ifdef SHIFT_ADD_SIGNED_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      exp = refMul(a, b, s);
      applyStimulus(a, b, s);
      waitDone(cyc);
      nChecks++;
      if (cyc !== LAT) begin nErrors++; $display("[TB] FAIL rand_latency i=%0d got=%0d exp=%0d", i, cyc, LAT); end
      nChecks++;
      if (product !== exp) begin
        nErrors++;
        $display("[TB] FAIL rand_product i=%0d a=%0d b=%0d s=%0b got=%h exp=%h", i, a, b, s, product, exp);
      end
      gap = $urandom_range(0, 3);
      for (int j = 0; j <= gap; j++) tick();
    end
  endtask

`ifdef SHIFT_ADD_SIGNED_EN
  // Directed signed cases, with the expected values written out literally.
  task automatic test_signed();
    int ops [4][3] = '{'{13, 5, 1}, '{8, 8, 1}, '{7, 15, 1}, '{13, 3, 0}};
    logic [2*N-1:0] lit [4] = '{8'hF1, 8'h40, 8'hF9, 8'h27};
    int cyc;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(ops[i][0], ops[i][1], ops[i][2][0]);
      waitDone(cyc);
      nChecks++;
      if (cyc !== LAT) begin nErrors++; $display("[TB] FAIL signed_latency i=%0d got=%0d exp=%0d", i, cyc, LAT); end
      nChecks++;
      if (product !== lit[i]) begin
        nErrors++;
        $display("[TB] FAIL signed_product i=%0d got=%h exp=%h", i, product, lit[i]);
      end
      tick();
    end
  endtask
`endif

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
`ifdef SHIFT_ADD_SIGNED_EN
    sgn    = 1'b0;
`endif
    test_reset();
    test_timing();
    tick();
    test_corners();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    tick();
    tick();
    test_random();
`ifdef SHIFT_ADD_SIGNED_EN
    test_signed();
`endif
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

  // Global watchdog so a stuck design still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
